// File: rtl/gpi_step_gen.sv
// Conditions the raw GPI bus (synchronise + debounce) and turns qualified rising
// edges on one selected bit into rate-limited single-cycle `ready` step strobes.
module gpi_step_gen #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_GAP         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] GPI,
    input  logic [3:0]       sel,
    input  logic             enable,
    input  logic             clr_ovf,
    output logic             ready,
    output logic [WIDTH-1:0] gpi_clean,
    output logic [3:0]       pending,
    output logic             overflow
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GAP_W = $clog2(MIN_GAP);
    localparam int PAD_W = (WIDTH > 16) ? WIDTH : 16;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_d;
    logic [DB_W-1:0]  db_cnt [WIDTH];
    logic [WIDTH-1:0] gpi_clean_d;

    logic [WIDTH-1:0] edges;
    logic [PAD_W-1:0] edges_pad;
    logic             rise;
    logic             issue;
    logic             ovf_set;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_d <= '0;
        end else begin
            sync_q[0] <= GPI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d <= s;
        end
    end

    // A bit is accepted only after it has differed from gpi_clean and held still
    // for DEBOUNCE_CYCLES consecutive synchronised samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
            gpi_clean   <= '0;
            gpi_clean_d <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((s[i] == gpi_clean[i]) || (s[i] != s_d[i])) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    gpi_clean[i] <= s[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            gpi_clean_d <= gpi_clean;
        end
    end

    // Padding to 16 bits makes select values beyond WIDTH land on constant zeros.
    always_comb begin
        edges     = gpi_clean & ~gpi_clean_d;
        edges_pad = PAD_W'(edges);
        rise      = edges_pad[sel];
        issue     = (state == IDLE) && enable && (pending != 4'd0);
        ovf_set   = rise && !issue && (pending == 4'hF);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (rise && !issue && (pending != 4'hF)) begin
                pending <= pending + 4'd1;
            end else if (issue && !rise) begin
                pending <= pending - 4'd1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // ready is a one-cycle strobe with no back-pressure: each strobe consumes one
    // queued request, and consecutive strobes are MIN_GAP clocks apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        ready   <= 1'b1;
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        ready <= 1'b0;
                    end
                end
                GAP: begin
                    ready <= 1'b0;
                    if (gap_cnt == GAP_ONE) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    ready   <= 1'b0;
                    gap_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpi_step_gen.sv
// Directed bench for gpi_step_gen: reset, debounce, spacing, saturation,
// simultaneous inc/dec and select-change behaviour against hand-computed values.
module tb_gpi_step_gen;

    logic        clk;
    logic        reset;
    logic [15:0] GPI;
    logic [3:0]  sel;
    logic        enable;
    logic        clr_ovf;
    logic        ready;
    logic [15:0] gpi_clean;
    logic [3:0]  pending;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // expected edge index of each ready strobe, and pending seen alongside it
    logic [15:0] exp_q[$];
    logic [15:0] pend_q[$];

    gpi_step_gen #(
        .WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .MIN_GAP(8)
    ) dut (
        .clk(clk), .reset(reset), .GPI(GPI), .sel(sel), .enable(enable),
        .clr_ovf(clr_ovf), .ready(ready), .gpi_clean(gpi_clean),
        .pending(pending), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pulse(input int bit_i, input int high_cycles, input int low_cycles);
        GPI[bit_i] = 1'b1;
        tick(high_cycles);
        GPI[bit_i] = 1'b0;
        tick(low_cycles);
    endtask

    // Called at a negedge; iteration c samples after posedge c. Optionally drops
    // GPI bits and raises enable just before edge drop_at / en_at.
    task automatic run_window(input int cycles, input int drop_at,
                              input logic [15:0] drop_mask, input int en_at);
        for (int c = 0; c < cycles; c++) begin
            if (c == drop_at) GPI = GPI & ~drop_mask;
            if (c == en_at) enable = 1'b1;
            @(negedge clk);
            if (ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'(ready), 32'd0);
                end else begin
                    check("ready_edge", 32'(c), 32'(exp_q.pop_front()));
                    if (pend_q.size() != 0)
                        check("pending_at_ready", 32'(pending), 32'(pend_q.pop_front()));
                end
            end
        end
        check("missing_ready", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        pend_q.delete();
    endtask

    initial begin
        reset   = 1'b0;
        GPI     = 16'hFFFF;
        sel     = 4'd0;
        enable  = 1'b1;
        clr_ovf = 1'b0;

        // reset state with all inputs high
        tick(3);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_clean", 32'(gpi_clean), 32'h0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        exp_q.push_back(16'd8);
        run_window(30, -1, 16'h0, -1);
        check("rst_clean_after", 32'(gpi_clean), 32'hFFFF);

        // debounce: 3-cycle glitch rejected, 6-cycle pulse accepted
        GPI = 16'h0;
        tick(20);
        check("settle_clean", 32'(gpi_clean), 32'h0);
        sel = 4'd3;
        GPI[3] = 1'b1;
        run_window(25, 3, 16'h0008, -1);
        check("glitch_clean", 32'(gpi_clean), 32'h0);
        GPI[3] = 1'b1;
        exp_q.push_back(16'd8);
        run_window(30, 6, 16'h0008, -1);
        check("deb_clean_after", 32'(gpi_clean), 32'h0);
        check("deb_pending", 32'(pending), 32'd0);

        // spacing: five queued requests released MIN_GAP apart
        sel = 4'd0;
        enable = 1'b0;
        for (int k = 0; k < 5; k++) drive_pulse(0, 6, 10);
        tick(4);
        check("queued5", 32'(pending), 32'd5);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(16'(k * 8));
            pend_q.push_back(16'(4 - k));
        end
        run_window(50, -1, 16'h0, 0);
        check("drained", 32'(pending), 32'd0);

        // saturation and overflow priority
        enable = 1'b0;
        for (int k = 0; k < 17; k++) drive_pulse(0, 6, 10);
        check("sat_pending", 32'(pending), 32'd15);
        check("sat_overflow", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        GPI[0] = 1'b1;
        tick(7);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("sat_hold", 32'(pending), 32'd15);
        GPI[0] = 1'b0;
        tick(12);

        // reset asserted while a strobe is high drops it and discards the queue
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (ready) break;
            @(negedge clk);
        end
        check("ready_before_rst", 32'(ready), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_pending", 32'(pending), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        run_window(20, -1, 16'h0, -1);

        // simultaneous inc and dec keep pending unchanged
        enable = 1'b0;
        drive_pulse(0, 6, 10);
        check("one_queued", 32'(pending), 32'd1);
        GPI[0] = 1'b1;
        exp_q.push_back(16'd7);
        exp_q.push_back(16'd15);
        pend_q.push_back(16'd1);
        pend_q.push_back(16'd0);
        run_window(30, 10, 16'h0001, 7);
        tick(10);

        // select change onto an already-clean bit, then a rise on the old bit
        GPI[5] = 1'b1;
        tick(12);
        check("bit5_clean", 32'(gpi_clean), 32'h0020);
        sel = 4'd5;
        run_window(20, -1, 16'h0, -1);
        GPI[0] = 1'b1;
        run_window(25, 6, 16'h0001, -1);
        check("sel_pending", 32'(pending), 32'd0);
        check("sel_clean", 32'(gpi_clean), 32'h0020);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
